cyber_player: RTL and testbench

Computer opponent for the tug-of-war game. Produces single-cycle press pulses on the same interface the human button path drives (one clean pulse per press, never two in adjacent cycles). Press rate is set by the switch-selected `speed` value compared against a free-running 10-bit LFSR. Its `press` output feeds the playfield logic in place of one player's conditioned button pulse.

---
 rtl/tug_pkg.sv | 19 +
 rtl/cyber_player_if.sv | 30 +++
 rtl/cyber_lfsr.sv | 29 ++
 rtl/cyber_player.sv | 79 +++++++
 tb/tb_cyber_player.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war game blocks.
//   TUG_LFSR_W  : width of the opponent LFSR and its speed threshold
//   LFSR_SEED   : LFSR value after reset (all-zero is legal for XNOR feedback)
//   TAP_HI/LO   : feedback taps for x^10 + x^7 + 1
//   cyber_state_t : computer-opponent press FSM states
package tug_pkg;

  localparam int TUG_LFSR_W = 10;
  localparam logic [TUG_LFSR_W-1:0] LFSR_SEED = '0;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } cyber_state_t;

endpackage

// File: rtl/cyber_player_if.sv
// Bundle between the computer opponent and its controller / playfield.
//   enable : arms the opponent
//   speed  : unsigned press threshold compared against the LFSR
//   press  : single-cycle press pulse
//   lfsr_q : current LFSR value (debug/visibility)
// master drives enable/speed, slave (the opponent) drives press/lfsr_q.
interface cyber_player_if #(
  parameter int LFSR_W = 10
);

  logic              enable;
  logic [LFSR_W-1:0] speed;
  logic              press;
  logic [LFSR_W-1:0] lfsr_q;

  modport master (
    output enable,
    output speed,
    input  press,
    input  lfsr_q
  );

  modport slave (
    input  enable,
    input  speed,
    output press,
    output lfsr_q
  );

endinterface

// File: rtl/cyber_lfsr.sv
// Free-running Fibonacci XNOR LFSR (x^10 + x^7 + 1).
//   clk   : system clock
//   reset : synchronous active-high, loads the seed
//   q     : current register value
// XNOR feedback makes all-ones the lockup state, so a zero seed is safe and
// the sequence covers every value except all-ones (period 1023).
module cyber_lfsr
  import tug_pkg::*;
#(
  parameter int LFSR_W = TUG_LFSR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= LFSR_W'(LFSR_SEED);
    end else begin
      lfsr_r <= {lfsr_r[LFSR_W-2:0], ~(lfsr_r[TAP_HI] ^ lfsr_r[TAP_LO])};
    end
  end

  assign q = lfsr_r;

endmodule

// File: rtl/cyber_player.sv
// Computer opponent for tug-of-war: emits clean one-cycle press pulses whose
// rate is set by comparing speed against a free-running LFSR.
//   clk   : system clock
//   reset : synchronous active-high
//   bus   : cyber_player_if slave (enable, speed in; press, lfsr_q out)
// Sequence per press: FIRE (press high) -> HOLD for GAP cycles -> IDLE, where
// IDLE spends at least one cycle evaluating the threshold. This gives a
// maximum rate of one pulse every GAP+2 cycles.
module cyber_player
  import tug_pkg::*;
#(
  parameter int LFSR_W = TUG_LFSR_W,
  parameter int GAP    = 2
) (
  input  logic           clk,
  input  logic           reset,
  cyber_player_if.slave  bus
);

  localparam int CNT_W = (GAP < 2) ? 1 : $clog2(GAP + 1);

  logic [LFSR_W-1:0] lfsr;
  logic              hit;
  cyber_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  cyber_lfsr #(
    .LFSR_W(LFSR_W)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .q    (lfsr)
  );

  // Compares against the LFSR value before this edge's update.
  assign hit = bus.enable && (bus.speed > lfsr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hit) state_d = FIRE;
      end
      FIRE: begin
        // Hold counter loads as HOLD is entered; HOLD ignores enable/hit.
        state_d = HOLD;
        cnt_d   = CNT_W'(GAP);
      end
      HOLD: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // press comes straight off the state register, so it is glitch-free.
  assign bus.press  = (state_q == FIRE);
  assign bus.lfsr_q = lfsr;

endmodule

// File: tb/tb_cyber_player.sv
module tb_cyber_player;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cyber_player_if #(.LFSR_W(10)) bus ();

  cyber_player #(
    .LFSR_W(10),
    .GAP   (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
  endtask

  function automatic logic [9:0] lfsr_model(input logic [9:0] v);
    return {v[8:0], ~(v[9] ^ v[6])};
  endfunction

  task automatic test_reset_lfsr();
    logic [9:0] exp_seq [7] = '{10'd1, 10'd3, 10'd7, 10'd15, 10'd31, 10'd63, 10'd127};
    logic [9:0] start;
    int         saw_max;
    bus.enable = 1'b0;
    bus.speed  = 10'd0;
    apply_reset();
    checks++;
    if (bus.lfsr_q !== 10'd0) begin
      errors++;
      $display("FAIL reset_lfsr: got %0d expected 0", bus.lfsr_q);
    end
    checks++;
    if (bus.press !== 1'b0) begin
      errors++;
      $display("FAIL reset_press: got %b expected 0", bus.press);
    end
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (bus.lfsr_q !== exp_seq[i]) begin
        errors++;
        $display("FAIL lfsr_seq[%0d]: got %0d expected %0d", i, bus.lfsr_q, exp_seq[i]);
      end
    end
    start   = 10'd127;
    saw_max = 0;
    for (int i = 0; i < 1023; i++) begin
      step();
      if (bus.lfsr_q === 10'd1023) saw_max++;
    end
    checks++;
    if (bus.lfsr_q !== start) begin
      errors++;
      $display("FAIL lfsr_period: got %0d expected %0d", bus.lfsr_q, start);
    end
    checks++;
    if (saw_max !== 0) begin
      errors++;
      $display("FAIL lfsr_lockup: saw 1023 %0d times expected 0", saw_max);
    end
  endtask

  task automatic test_speed_zero();
    int pulses;
    bus.speed  = 10'd0;
    bus.enable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 2100; i++) begin
      step();
      if (bus.press === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL speed_zero: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_max_rate();
    logic exp;
    bus.enable = 1'b1;
    bus.speed  = 10'd1023;
    apply_reset();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      exp = ((i % 4) == 0);
      checks++;
      if (bus.press !== exp) begin
        errors++;
        $display("FAIL max_rate[%0d]: got %b expected %b", i, bus.press, exp);
      end
    end
  endtask

  // Follows test_max_rate: FSM is in IDLE at this point.
  task automatic test_enable_low();
    int pulses;
    bus.enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.press !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL enable_low: got %0d high cycles expected 0", pulses);
    end
    bus.enable = 1'b1;
    step();
    checks++;
    if (bus.press !== 1'b1) begin
      errors++;
      $display("FAIL enable_rise: got %b expected 1", bus.press);
    end
    step();
    checks++;
    if (bus.press !== 1'b0) begin
      errors++;
      $display("FAIL enable_rise_width: got %b expected 0", bus.press);
    end
  endtask

  task automatic test_enable_drop();
    bus.enable = 1'b1;
    bus.speed  = 10'd1023;
    apply_reset();
    reset = 1'b0;
    step();
    checks++;
    if (bus.press !== 1'b1) begin
      errors++;
      $display("FAIL drop_first_pulse: got %b expected 1", bus.press);
    end
    bus.enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (bus.press !== 1'b0) begin
        errors++;
        $display("FAIL enable_drop[%0d]: got %b expected 0", i, bus.press);
      end
    end
  endtask

  task automatic test_reset_fire();
    bus.enable = 1'b1;
    bus.speed  = 10'd1023;
    apply_reset();
    reset = 1'b0;
    step();
    checks++;
    if (bus.press !== 1'b1) begin
      errors++;
      $display("FAIL rst_fire_pulse: got %b expected 1", bus.press);
    end
    reset = 1'b1;
    step();
    checks++;
    if (bus.press !== 1'b0) begin
      errors++;
      $display("FAIL rst_fire_press: got %b expected 0", bus.press);
    end
    checks++;
    if (bus.lfsr_q !== 10'd0) begin
      errors++;
      $display("FAIL rst_fire_lfsr: got %0d expected 0", bus.lfsr_q);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (bus.press !== 1'b1 || bus.lfsr_q !== 10'd1) begin
      errors++;
      $display("FAIL rst_fire_restart: got press=%b lfsr=%0d expected press=1 lfsr=1",
               bus.press, bus.lfsr_q);
    end
  endtask

  task automatic test_speed_512();
    logic [9:0] prev_lfsr;
    logic [9:0] model;
    logic       exp;
    int         low_run;
    int         pulses;
    bus.enable = 1'b1;
    bus.speed  = 10'd512;
    apply_reset();
    reset     = 1'b0;
    prev_lfsr = 10'd0;
    model     = 10'd0;
    low_run   = 3;
    pulses    = 0;
    for (int i = 0; i < 4092; i++) begin
      step();
      model = lfsr_model(model);
      // low_run >= 3 means the FSM was in IDLE before this edge.
      exp = (low_run >= 3) && (prev_lfsr < 10'd512);
      checks++;
      if (bus.press !== exp) begin
        errors++;
        $display("FAIL s512_press[%0d]: got %b expected %b (prev lfsr %0d)",
                 i, bus.press, exp, prev_lfsr);
      end
      checks++;
      if (bus.lfsr_q !== model) begin
        errors++;
        $display("FAIL s512_lfsr[%0d]: got %0d expected %0d", i, bus.lfsr_q, model);
      end
      if (bus.press === 1'b1) begin
        pulses++;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_lfsr = bus.lfsr_q;
    end
    checks++;
    if (!(pulses > 0 && pulses < 1023)) begin
      errors++;
      $display("FAIL s512_count: got %0d pulses expected 1..1022", pulses);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.speed  = 10'd0;
    @(negedge clk);
    test_reset_lfsr();
    test_speed_zero();
    test_max_rate();
    test_enable_low();
    test_enable_drop();
    test_reset_fire();
    test_speed_512();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
